mem_stage_ctrl: RTL

//  Memory-stage sequencer. Consumes the registered outputs of the EX/MEM pipeline latch.

---
 rtl/mem_stage_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage sequencer behind the EX/MEM latch.
// Issues the dcache request and holds it until dhit, stalling the pipeline meanwhile.
// Presents a one-cycle-valid bundle to MEM/WB and owns the sticky halt.
// Optional feature: define MEM_TIMEOUT_EN to add the ACCESS watchdog and the timeout_err_o port.

module mem_stage_ctrl
`ifdef MEM_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
   input  logic        clk_i,
   input  logic        rst_i,
   // EX/MEM latch outputs
   input  logic        in_valid_i,
   input  logic        flush_i,
   input  logic        dren_i,
   input  logic        dwen_i,
   input  logic        reg_write_i,
   input  logic        halt_i,
   input  logic [1:0]  mem_to_reg_i,
   input  logic [4:0]  wsel_i,
   input  logic [31:0] porto_i,
   input  logic [31:0] pcp4_i,
   input  logic [31:0] lui_i,
   input  logic [31:0] dmemstr_i,
   // dcache response
   input  logic        dhit_i,
   input  logic [31:0] dmemload_i,
   // dcache request
   output logic        dmem_ren_o,
   output logic        dmem_wen_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_store_o,
   // pipeline control
   output logic        mem_stall_o,
   // MEM/WB bundle
   output logic        wb_valid_o,
   output logic        wb_reg_write_o,
   output logic [1:0]  wb_mem_to_reg_o,
   output logic [4:0]  wb_wsel_o,
   output logic [31:0] wb_porto_o,
   output logic [31:0] wb_pcp4_o,
   output logic [31:0] wb_lui_o,
   output logic [31:0] wb_dload_o,
   output logic        halt_o
`ifdef MEM_TIMEOUT_EN
   ,
   output logic        timeout_err_o
`endif
);

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StHalted
   } state_e;

   state_e      state_q;

   // Request registers driven straight onto the dcache interface
   logic        dmem_ren_q;
   logic        dmem_wen_q;
   logic [31:0] dmem_addr_q;
   logic [31:0] dmem_store_q;

   // Writeback fields parked while the access is in flight
   logic        cap_reg_write_q;
   logic [1:0]  cap_mem_to_reg_q;
   logic [4:0]  cap_wsel_q;
   logic [31:0] cap_porto_q;
   logic [31:0] cap_pcp4_q;
   logic [31:0] cap_lui_q;

   // MEM/WB bundle registers
   logic        wb_valid_q;
   logic        wb_reg_write_q;
   logic [1:0]  wb_mem_to_reg_q;
   logic [4:0]  wb_wsel_q;
   logic [31:0] wb_porto_q;
   logic [31:0] wb_pcp4_q;
   logic [31:0] wb_lui_q;
   logic [31:0] wb_dload_q;

   logic        halt_q;

   logic        accept;
   logic        is_mem_op;

   // Decode of the instruction offered this cycle
   always_comb begin
      accept    = (state_q == StIdle) && in_valid_i && !flush_i;
      is_mem_op = dren_i || dwen_i;
   end

   // Sequencer: state, request, bundle and halt all registered in one place
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= StIdle;
         dmem_ren_q       <= 1'b0;
         dmem_wen_q       <= 1'b0;
         dmem_addr_q      <= '0;
         dmem_store_q     <= '0;
         cap_reg_write_q  <= 1'b0;
         cap_mem_to_reg_q <= '0;
         cap_wsel_q       <= '0;
         cap_porto_q      <= '0;
         cap_pcp4_q       <= '0;
         cap_lui_q        <= '0;
         wb_valid_q       <= 1'b0;
         wb_reg_write_q   <= 1'b0;
         wb_mem_to_reg_q  <= '0;
         wb_wsel_q        <= '0;
         wb_porto_q       <= '0;
         wb_pcp4_q        <= '0;
         wb_lui_q         <= '0;
         wb_dload_q       <= '0;
         halt_q           <= 1'b0;
      end else begin
         // wb_valid is a pulse; only a completing instruction raises it
         wb_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (halt_i) begin
                     state_q <= StHalted;
                     halt_q  <= 1'b1;
                  end else if (is_mem_op) begin
                     state_q          <= StAccess;
                     dmem_wen_q       <= dwen_i;
                     // Store wins when both request bits are set
                     dmem_ren_q       <= dren_i & ~dwen_i;
                     dmem_addr_q      <= porto_i;
                     dmem_store_q     <= dmemstr_i;
                     cap_reg_write_q  <= reg_write_i;
                     cap_mem_to_reg_q <= mem_to_reg_i;
                     cap_wsel_q       <= wsel_i;
                     cap_porto_q      <= porto_i;
                     cap_pcp4_q       <= pcp4_i;
                     cap_lui_q        <= lui_i;
                  end else begin
                     // ALU op bypasses the cache with one cycle of latency
                     wb_valid_q      <= 1'b1;
                     wb_reg_write_q  <= reg_write_i;
                     wb_mem_to_reg_q <= mem_to_reg_i;
                     wb_wsel_q       <= wsel_i;
                     wb_porto_q      <= porto_i;
                     wb_pcp4_q       <= pcp4_i;
                     wb_lui_q        <= lui_i;
                     wb_dload_q      <= '0;
                  end
               end
            end
            StAccess: begin
               // Request is held untouched; in_valid and flush cannot abort it
               if (dhit_i) begin
                  state_q         <= StIdle;
                  dmem_ren_q      <= 1'b0;
                  dmem_wen_q      <= 1'b0;
                  wb_valid_q      <= 1'b1;
                  wb_reg_write_q  <= cap_reg_write_q;
                  wb_mem_to_reg_q <= cap_mem_to_reg_q;
                  wb_wsel_q       <= cap_wsel_q;
                  wb_porto_q      <= cap_porto_q;
                  wb_pcp4_q       <= cap_pcp4_q;
                  wb_lui_q        <= cap_lui_q;
                  wb_dload_q      <= dmem_ren_q ? dmemload_i : 32'h0;
               end
            end
            StHalted: begin
               // Terminal until reset
               halt_q     <= 1'b1;
               dmem_ren_q <= 1'b0;
               dmem_wen_q <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef MEM_TIMEOUT_EN
   // Last count value at which a missing dhit trips the watchdog
   localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt_q;
   logic       timeout_err_q;

   // Watchdog: counts ACCESS cycles without dhit; the error is sticky, the request is not aborted
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else if (state_q != StAccess) begin
         // Holding zero outside ACCESS gives a cleared count on entry
         tmo_cnt_q <= '0;
      end else if (!dhit_i) begin
         if (tmo_cnt_q == TmoLast) begin
            timeout_err_q <= 1'b1;
         end
         if (tmo_cnt_q != 8'hFF) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
         end
      end
   end

   assign timeout_err_o = timeout_err_q;
`endif

   // Stall is the only combinational output so upstream releases in the dhit cycle
   always_comb begin
      mem_stall_o = (state_q == StAccess) && !dhit_i;
   end

   assign dmem_ren_o      = dmem_ren_q;
   assign dmem_wen_o      = dmem_wen_q;
   assign dmem_addr_o     = dmem_addr_q;
   assign dmem_store_o    = dmem_store_q;
   assign wb_valid_o      = wb_valid_q;
   assign wb_reg_write_o  = wb_reg_write_q;
   assign wb_mem_to_reg_o = wb_mem_to_reg_q;
   assign wb_wsel_o       = wb_wsel_q;
   assign wb_porto_o      = wb_porto_q;
   assign wb_pcp4_o       = wb_pcp4_q;
   assign wb_lui_o        = wb_lui_q;
   assign wb_dload_o      = wb_dload_q;
   assign halt_o          = halt_q;

endmodule
